// File: rtl/data_ram_resp_pkg.sv
// Shared constants and helpers for the data RAM responder.
// Holds the MMIO tag default, timer register offsets, ID value, STATUS bit
// indices and the byte-lane merge function used by every writable register.
package data_ram_resp_pkg;

  localparam logic [3:0]  MMIO_TAG_DEF = 4'h1;

  // Register offsets, as addr[3:2] inside the MMIO window
  localparam logic [1:0]  OFF_COUNT   = 2'd0;
  localparam logic [1:0]  OFF_COMPARE = 2'd1;
  localparam logic [1:0]  OFF_STATUS  = 2'd2;
  localparam logic [1:0]  OFF_ID      = 2'd3;

  localparam logic [31:0] ID_VALUE    = 32'h4D49_5053;

  localparam int          STATUS_MATCH_BIT = 0;
  localparam int          STATUS_EN_BIT    = 1;

  // Lanes with sel[i]=1 take new_v, the rest keep base_v.
  function automatic logic [31:0] lane_merge(input logic [31:0] base_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : base_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram_resp_if.sv
// CPU data-memory port between the MEM stage (master) and the data RAM (slave).
// Signals: ce/we access control, addr byte address, sel byte lanes,
// data_i write data toward memory, data_o combinational read data back.
interface data_ram_resp_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce, we, addr, sel, data_i, input  data_o);
  modport slave  (input  ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/data_ram_resp_mmio_timer.sv
// Timer register block: free-running COUNT, COMPARE, STATUS{EN,MATCH}, read-only ID.
// Ports: clk/rst, wr_en+off+sel+wdata write side, off selects rdata,
// timer_int is MATCH & EN taken straight from flops.
module data_ram_resp_mmio_timer
  import data_ram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  off,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_int
);

  logic [31:0] count;
  logic [31:0] compare;
  logic        en;
  logic        match;

  logic [31:0] count_inc;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        match_set;
  logic        match_clr;
  logic        match_next;

  assign count_inc  = count + 32'd1;
  assign wr_count   = wr_en && (off == OFF_COUNT);
  assign wr_compare = wr_en && (off == OFF_COMPARE);
  assign wr_status  = wr_en && (off == OFF_STATUS);

  // Compare uses the pre-update register values.
  assign match_set  = en && (count == compare);
  assign match_clr  = wr_status && sel[0] && wdata[STATUS_MATCH_BIT];

  // Set beats a simultaneous write-1-to-clear.
  always_comb begin
    match_next = match;
    if (match_clr) match_next = 1'b0;
    if (match_set) match_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      compare <= '0;
      en      <= 1'b0;
      match   <= 1'b0;
    end else begin
      // Written lanes override the increment; unwritten lanes keep counting.
      count <= wr_count ? lane_merge(count_inc, wdata, sel) : count_inc;
      if (wr_compare) compare <= lane_merge(compare, wdata, sel);
      if (wr_status && sel[0]) en <= wdata[STATUS_EN_BIT];
      match <= match_next;
    end
  end

  assign timer_int = match & en;

  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_COUNT:   rdata = count;
      OFF_COMPARE: rdata = compare;
      OFF_STATUS: begin
        rdata[STATUS_MATCH_BIT] = match;
        rdata[STATUS_EN_BIT]    = en;
      end
      OFF_ID:      rdata = ID_VALUE;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: word RAM with byte-lane writes plus a timer/ID MMIO window.
// Ports: clk, rst (async active-low), bus (slave modport, data_o combinational),
// timer_int_o timer interrupt level, bad_addr_o one-cycle pulse after an unmapped access.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int         ADDR_W    = 17,
  parameter logic [3:0] MMIO_TAG  = MMIO_TAG_DEF,
  parameter string      INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  data_ram_resp_if.slave   bus,
  output logic             timer_int_o,
  output logic             bad_addr_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [0:DEPTH-1];

  logic              mmio_hit;
  logic              mmio_ok;
  logic              ram_ok;
  logic [ADDR_W-1:0] word_idx;
  logic              rd_en;
  logic              wr_en;
  logic              bad_now;
  logic [31:0]       mmio_rdata;

  // Alignment is carried by sel, so the low address bits are never decoded.
  logic unused_addr_lo;
  assign unused_addr_lo = &{1'b0, bus.addr[1:0]};

  assign mmio_hit = (bus.addr[31:28] == MMIO_TAG);
  assign mmio_ok  = mmio_hit && (bus.addr[27:4] == 24'd0);
  // Any set bit above the word index in [27:0] means out of range; no aliasing.
  assign ram_ok   = !mmio_hit && ((bus.addr[27:0] >> (ADDR_W + 2)) == 28'd0);
  assign word_idx = bus.addr[ADDR_W+1:2];

  assign rd_en    = bus.ce && !bus.we;
  assign wr_en    = bus.ce && bus.we;
  assign bad_now  = bus.ce && !mmio_ok && !ram_ok;

  data_ram_resp_mmio_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en && mmio_ok),
    .off       (bus.addr[3:2]),
    .sel       (bus.sel),
    .wdata     (bus.data_i),
    .rdata     (mmio_rdata),
    .timer_int (timer_int_o)
  );

  // RAM has no reset; a write is simply suppressed while rst is low at the edge.
  always_ff @(posedge clk) begin
    if (rst && wr_en && ram_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sel[i]) mem[word_idx][8*i +: 8] <= bus.data_i[8*i +: 8];
      end
    end
  end

  // Combinational read sees the pre-edge contents, so a same-cycle write is not visible yet.
  always_comb begin
    bus.data_o = '0;
    if (rd_en) begin
      if (mmio_ok)     bus.data_o = mmio_rdata;
      else if (ram_ok) bus.data_o = mem[word_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bad_addr_o <= 1'b0;
    else      bad_addr_o <= bad_now;
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: each issued access pushes its expected
// data_o (and optionally bad_addr_o / timer_int_o) into a queue; a negedge
// monitor pops and compares whenever the DUT sees ce=1.
module tb_data_ram_resp;

  localparam logic [31:0] A_COUNT   = 32'h1000_0000;
  localparam logic [31:0] A_COMPARE = 32'h1000_0004;
  localparam logic [31:0] A_STATUS  = 32'h1000_0008;
  localparam logic [31:0] A_ID      = 32'h1000_000C;
  localparam logic [31:0] A_BADMMIO = 32'h1000_0010;
  localparam logic [31:0] A_OOR     = 32'h0008_0010;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        chk_bad;
    logic        bad;
    logic        chk_int;
    logic        intr;
  } item_t;

  logic clk;
  logic rst;
  logic timer_int;
  logic bad_addr;

  item_t exp_q[$];
  int    n_tests;
  int    n_fail;
  int    next_id;

  data_ram_resp_if bus ();

  data_ram_resp dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .timer_int_o (timer_int),
    .bad_addr_o  (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %08h expected %08h", nm, id, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per ce=1 cycle.
  always @(negedge clk) begin
    if (bus.ce) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_access: addr %08h with empty scoreboard", bus.addr);
      end else begin
        item_t it;
        it = exp_q.pop_front();
        check("data_o", it.id, bus.data_o, it.data);
        if (it.chk_bad) check("bad_addr_o", it.id, {31'd0, bad_addr}, {31'd0, it.bad});
        if (it.chk_int) check("timer_int_o", it.id, {31'd0, timer_int}, {31'd0, it.intr});
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic cb, input logic b,
                      input logic ci, input logic i);
    item_t it;
    it.id = next_id; it.data = d; it.chk_bad = cb; it.bad = b; it.chk_int = ci; it.intr = i;
    next_id++;
    exp_q.push_back(it);
  endtask

  // Inputs change 1 time unit after a rising edge and hold through the next one.
  task automatic drive(input logic c, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    bus.ce = c; bus.we = w; bus.addr = a; bus.sel = s; bus.data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input logic cb, input logic b, input logic ci, input logic i);
    push(exp, cb, b, ci, i);
    drive(1'b1, 1'b0, a, 4'hF, 32'd0);
  endtask

  // Writes always present data_o = 0.
  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, a, s, d);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; next_id = 0;
    rst = 1'b0;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.data_i = '0;
    @(posedge clk); #1;

    // Reset state
    rd(A_COUNT,  32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    rd(A_STATUS, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;

    // Full-word write then single-lane write
    wr(32'h10, 4'b1111, 32'h1122_3344);
    rd(32'h10, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 1'b0);
    wr(32'h10, 4'b0100, 32'hAABB_CCDD);
    rd(32'h10, 32'h11BB_3344, 1'b0, 1'b0, 1'b0, 1'b0);

    // Old value before the write, new value the cycle after
    wr(32'h20, 4'b1111, 32'h0102_0304);
    rd(32'h20, 32'h0102_0304, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(32'h20, 4'b1111, 32'hDEAD_BEEF);
    rd(32'h20, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timer compare: COUNT reads 0..5, MATCH/int appear the cycle after 5
    wr(A_COMPARE, 4'hF, 32'd5);
    wr(A_STATUS,  4'hF, 32'd2);
    wr(A_COUNT,   4'hF, 32'd0);
    for (int k = 0; k < 6; k++) rd(A_COUNT, k, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(A_COUNT,  32'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    rd(A_STATUS, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    wr(A_STATUS, 4'hF, 32'd3);
    rd(A_STATUS, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0);

    // Wrap and byte-lane merge with increment
    wr(A_COUNT, 4'hF, 32'hFFFF_FFFF);
    rd(A_COUNT, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(A_COUNT, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(A_COUNT, 4'hF, 32'h1234_5600);
    wr(A_COUNT, 4'b0001, 32'h0000_00AA);
    rd(A_COUNT, 32'h1234_56AA, 1'b0, 1'b0, 1'b0, 1'b0);

    // ID is read-only and not a bad address
    rd(A_ID, 32'h4D49_5053, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(A_ID, 4'hF, 32'h0000_0000);
    rd(A_ID, 32'h4D49_5053, 1'b1, 1'b0, 1'b0, 1'b0);

    // Unmapped MMIO read: returns 0, one-cycle bad pulse
    rd(A_BADMMIO, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(32'h10, 32'h11BB_3344, 1'b1, 1'b1, 1'b0, 1'b0);
    rd(32'h10, 32'h11BB_3344, 1'b1, 1'b0, 1'b0, 1'b0);

    // Out-of-range RAM write dropped, out-of-range read returns 0
    wr(A_OOR, 4'hF, 32'hFFFF_FFFF);
    rd(32'h10, 32'h11BB_3344, 1'b1, 1'b1, 1'b0, 1'b0);
    rd(A_OOR, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(32'h10, 32'h11BB_3344, 1'b1, 1'b1, 1'b0, 1'b0);

    // Mid-cycle reset while a bad pulse and a nonzero COUNT are live
    rd(A_BADMMIO, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = A_COUNT; bus.sel = 4'hF; bus.data_i = '0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rd(A_STATUS, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    rd(A_COUNT, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(A_COUNT, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(32'h10, 32'h11BB_3344, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(32'h20, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    check("scoreboard_left", 0, exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
